// File: rtl/conv_stream_feeder.sv
// ---------------------------------------------------------------------------
// conv_stream_feeder
//
// Transmit side of the a/b operand stream. On an accepted start it reads
// LENGTH consecutive words from an external synchronous-read memory, starting
// at BASE_ADDR. It presents them on a valid/ready stream, each word with a
// zero flag. A small output FIFO absorbs the one-cycle memory latency, so the
// stream runs at one word per cycle while the consumer keeps ready high.
//
// Ports
//   clk            rising-edge clock for all logic
//   srst_in        synchronous reset, active high
//   start          one-cycle pulse that begins a transfer; ignored while busy
//   base_addr      first read address, sampled on an accepted start
//   length         number of words to send, sampled on an accepted start
//   busy           a transfer is in progress
//   done           one-cycle pulse after the final word handshakes
//   mem_re         memory read enable
//   mem_addr       memory read address (wraps modulo the address space)
//   mem_rdata      memory read data, valid one cycle after mem_re
//   out_data       stream data (FIFO head)
//   out_zero_flag  set when out_data is all zeros
//   out_valid      stream valid (FIFO not empty)
//   out_ready      stream ready from the consumer
// ---------------------------------------------------------------------------
module conv_stream_feeder #(
    parameter int DATA_WIDTH     = 16,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int LEN_WIDTH      = 16,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                      clk,
    input  logic                      srst_in,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]      length,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_re,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_zero_flag,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = FIFO_DEPTH[CNT_W:0];

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN
    } state_e;

    state_e                    state_q;
    logic [MEM_ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]      len_q;
    logic [LEN_WIDTH-1:0]      issued_q;
    logic [LEN_WIDTH-1:0]      sent_q;
    logic                      done_q;
    logic                      rd_pending_q;

    logic [DATA_WIDTH-1:0]     fifo_data_q [FIFO_DEPTH];
    logic                      fifo_zero_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [CNT_W-1:0]          count_q;
    logic [CNT_W-1:0]          count_d;

    logic                      handshake;
    logic                      push;
    logic                      issue;
    logic                      last_issue;
    logic                      last_send;
    logic [LEN_WIDTH-1:0]      len_m1;
    logic [CNT_W:0]            committed;

    assign out_valid     = (count_q != '0);
    assign out_data      = fifo_data_q[rd_ptr_q];
    assign out_zero_flag = fifo_zero_q[rd_ptr_q];
    assign handshake     = out_valid & out_ready;

    // A read issued last cycle always returns now, so it always lands in the FIFO.
    assign push = rd_pending_q;

    // Slots already spoken for once this cycle completes. These are the words
    // held now plus the word arriving now, minus the word leaving now.
    // Counting the pop keeps a depth-2 FIFO streaming at one word per cycle.
    // A read is issued only while a slot is still free, so the FIFO cannot
    // overflow.
    assign committed = {1'b0, count_q}
                     + {{CNT_W{1'b0}}, rd_pending_q}
                     - {{CNT_W{1'b0}}, handshake};

    assign issue      = (state_q == ST_STREAM) && (committed < DEPTH_C);
    assign len_m1     = len_q - 1'b1;
    assign last_issue = issue && (issued_q == len_m1);
    assign last_send  = handshake && (sent_q == len_m1);

    assign mem_re   = issue;
    assign mem_addr = base_q + MEM_ADDR_WIDTH'(issued_q);
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

    assign count_d = count_q + CNT_W'(push) - CNT_W'(handshake);

    // Transfer control. A zero-length transfer goes straight to DRAIN.
    // It then stays busy for a single cycle before done pulses.
    always_ff @(posedge clk) begin
        if (srst_in) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            len_q        <= '0;
            issued_q     <= '0;
            sent_q       <= '0;
            done_q       <= 1'b0;
            rd_pending_q <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            rd_pending_q <= issue;
            if (handshake) begin
                sent_q <= sent_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        len_q    <= length;
                        issued_q <= '0;
                        sent_q   <= '0;
                        state_q  <= (length == '0) ? ST_DRAIN : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (issue) begin
                        issued_q <= issued_q + 1'b1;
                    end
                    if (last_issue) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((len_q == '0) || last_send) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Output FIFO: the zero flag is computed on entry so it travels with its word.
    always_ff @(posedge clk) begin
        if (srst_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_zero_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= mem_rdata;
                fifo_zero_q[wr_ptr_q] <= (mem_rdata == '0);
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (handshake) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// ---------------------------------------------------------------------------
// tb_conv_stream_feeder
//
// Directed bench for conv_stream_feeder. A synchronous-read memory model
// feeds the DUT. A reference model, kept as queues of expected words and
// read addresses, is checked every cycle against the stream, the read port,
// busy and done. Literal expectations per scenario pin the reference model.
// ---------------------------------------------------------------------------
module tb_conv_stream_feeder;

    logic        clk;
    logic        srst_in;
    logic        start;
    logic [7:0]  base_addr;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic        mem_re;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] out_data;
    logic        out_zero_flag;
    logic        out_valid;
    logic        out_ready;

    conv_stream_feeder #(
        .DATA_WIDTH    (16),
        .MEM_ADDR_WIDTH(8),
        .LEN_WIDTH     (16),
        .FIFO_DEPTH    (2)
    ) dut (
        .clk          (clk),
        .srst_in      (srst_in),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .mem_re       (mem_re),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .out_data     (out_data),
        .out_zero_flag(out_zero_flag),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Memory model: one-cycle synchronous read.
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (mem_re === 1'b1) mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) cyc++;

    // Reference model state
    logic [15:0] expQ [$];
    logic [7:0]  addrQ [$];
    int          outstanding = 0;
    int          doneDue     = -1;
    int          activeFrom  = -1;
    int          hsTotal     = 0;
    int          doneCount   = 0;
    logic        prevValid   = 1'b0;
    logic        prevReady   = 1'b0;
    logic [15:0] prevData    = '0;
    logic        prevZero    = 1'b0;

    // Logs for literal per-scenario checks
    logic [15:0] hsLog [$];
    int          hsCycLog [$];
    logic [7:0]  rdAddrLog [$];

    logic [15:0] expWord;
    logic [7:0]  expAddr;
    logic        expDone;
    logic        expBusy;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Compare process: runs on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (srst_in !== 1'b0) begin
            expQ.delete();
            addrQ.delete();
            outstanding = 0;
            doneDue     = -1;
            activeFrom  = -1;
            prevValid   = 1'b0;
        end else begin
            if (prevValid && !prevReady) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prevData || out_zero_flag !== prevZero) begin
                    failures++;
                    $display("[TB] FAIL stall_hold: got valid=%b data=0x%0h zero=%b expected valid=1 data=0x%0h zero=%b",
                             out_valid, out_data, out_zero_flag, prevData, prevZero);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                hsTotal++;
                outstanding--;
                hsLog.push_back(out_data);
                hsCycLog.push_back(cyc);
                if (expQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL extra_word: got 0x%0h expected no word (cycle %0d)", out_data, cyc);
                end else begin
                    expWord = expQ.pop_front();
                    if (out_data !== expWord || out_zero_flag !== (expWord == 16'h0)) begin
                        failures++;
                        $display("[TB] FAIL stream_word: got 0x%0h/z%b expected 0x%0h/z%b",
                                 out_data, out_zero_flag, expWord, (expWord == 16'h0));
                    end
                    if (expQ.size() == 0) doneDue = cyc + 1;
                end
            end
            if (mem_re !== 1'b0) begin
                checks++;
                outstanding++;
                rdAddrLog.push_back(mem_addr);
                if (addrQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL extra_read: got addr 0x%0h expected no read", mem_addr);
                end else begin
                    expAddr = addrQ.pop_front();
                    if (mem_addr !== expAddr) begin
                        failures++;
                        $display("[TB] FAIL read_addr: got 0x%0h expected 0x%0h", mem_addr, expAddr);
                    end
                end
            end
            checkOutput("fifo_overfill", (outstanding > 2) ? 32'd1 : 32'd0, 32'd0);
            expDone = (doneDue == cyc);
            expBusy = (activeFrom >= 0) && (cyc >= activeFrom) && !expDone;
            checkOutput("done_pulse", {31'd0, done}, {31'd0, expDone});
            checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
            if (done === 1'b1) doneCount++;
            if (expDone) begin
                doneDue = -1;
                if (activeFrom >= 0 && activeFrom <= cyc) activeFrom = -1;
            end
            prevValid = (out_valid === 1'b1);
            prevReady = (out_ready === 1'b1);
            prevData  = out_data;
            prevZero  = out_zero_flag;
        end
    end

    // Drives a one-cycle start pulse. When the DUT should accept it,
    // the expected words and addresses are queued in the model.
    task automatic applyStimulus(input logic [7:0] base, input logic [15:0] len, input bit accepted);
        logic [7:0] a;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = base;
        length    = len;
        if (accepted) begin
            for (int i = 0; i < int'(len); i++) begin
                a = base + 8'(i);
                expQ.push_back(mem[a]);
                addrQ.push_back(a);
            end
            activeFrom = cyc + 1;
            if (len == 16'd0) doneDue = cyc + 2;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (activeFrom < 0 && expQ.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checkOutput({name, "_timeout"}, (i >= budget) ? 32'd1 : 32'd0, 32'd0);
    endtask

    task automatic clearLogs();
        hsLog.delete();
        hsCycLog.delete();
        rdAddrLog.delete();
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({name, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({name, "_mem_re"}, {31'd0, mem_re}, 32'd0);
        checkOutput({name, "_mem_addr"}, {24'd0, mem_addr}, 32'd0);
        checkOutput({name, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        checkOutput({name, "_out_data"}, {16'd0, out_data}, 32'd0);
        checkOutput({name, "_out_zero"}, {31'd0, out_zero_flag}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    logic [15:0] t1Exp [4];
    logic [7:0]  t2Addr [4];
    logic [15:0] t2Exp [4];
    logic [15:0] t3Exp [6];
    logic [39:0] readyPat;
    int          d0;
    int          h0;

    initial begin
        srst_in   = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = {8'(i), ~8'(i)};
        mem[8'h10] = 16'd5;
        mem[8'h11] = 16'd0;
        mem[8'h12] = 16'd7;
        mem[8'h13] = 16'd9;
        mem[8'h22] = 16'd0;

        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        srst_in = 1'b0;

        // T1: four words, ready held high
        $display("[TB] T1 basic stream");
        t1Exp = '{16'd5, 16'd0, 16'd7, 16'd9};
        clearLogs();
        d0 = doneCount;
        applyStimulus(8'h10, 16'd4, 1'b1);
        waitIdle("t1", 40);
        checkOutput("t1_count", hsLog.size(), 4);
        for (int i = 0; i < 4; i++)
            checkOutput("t1_data", (i < hsLog.size()) ? {16'd0, hsLog[i]} : 32'hDEAD_BEEF, {16'd0, t1Exp[i]});
        checkOutput("t1_back_to_back", (hsCycLog.size() == 4) ? 32'(hsCycLog[3] - hsCycLog[0]) : 32'hFFFF_FFFF, 32'd3);
        checkOutput("t1_done_count", 32'(doneCount - d0), 32'd1);

        // T2: address wrap FE,FF,00,01
        $display("[TB] T2 address wrap");
        t2Addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        t2Exp  = '{16'hFE01, 16'hFF00, 16'h00FF, 16'h01FE};
        clearLogs();
        applyStimulus(8'hFE, 16'd4, 1'b1);
        waitIdle("t2", 40);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_addr", (i < rdAddrLog.size()) ? {24'd0, rdAddrLog[i]} : 32'hDEAD_BEEF, {24'd0, t2Addr[i]});
            checkOutput("t2_data", (i < hsLog.size()) ? {16'd0, hsLog[i]} : 32'hDEAD_BEEF, {16'd0, t2Exp[i]});
        end

        // T3: irregular ready, including ten stalled cycles
        $display("[TB] T3 backpressure");
        t3Exp    = '{16'h20DF, 16'h21DE, 16'h0000, 16'h23DC, 16'h24DB, 16'h25DA};
        readyPat = 40'b1111_1011_1010_0111_0100_0000_0000_1101_0000_0000;
        clearLogs();
        out_ready = 1'b0;
        applyStimulus(8'h20, 16'd6, 1'b1);
        for (int i = 0; i < 40; i++) begin
            out_ready = readyPat[i];
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        waitIdle("t3", 40);
        checkOutput("t3_count", hsLog.size(), 6);
        for (int i = 0; i < 6; i++)
            checkOutput("t3_data", (i < hsLog.size()) ? {16'd0, hsLog[i]} : 32'hDEAD_BEEF, {16'd0, t3Exp[i]});

        // T4: zero length, a start on the done cycle, a start while busy
        $display("[TB] T4 zero length and start handling");
        clearLogs();
        d0 = doneCount;
        applyStimulus(8'h30, 16'd0, 1'b1);
        applyStimulus(8'h60, 16'd2, 1'b1);
        applyStimulus(8'h70, 16'd5, 1'b0);
        waitIdle("t4", 40);
        checkOutput("t4_reads", rdAddrLog.size(), 2);
        checkOutput("t4_first_addr", (rdAddrLog.size() > 0) ? {24'd0, rdAddrLog[0]} : 32'hDEAD_BEEF, 32'h60);
        checkOutput("t4_words", hsLog.size(), 2);
        checkOutput("t4_last_word", (hsLog.size() > 1) ? {16'd0, hsLog[1]} : 32'hDEAD_BEEF, 32'h619E);
        checkOutput("t4_done_count", 32'(doneCount - d0), 32'd2);

        // T5: reset mid-transfer, then a fresh transfer
        $display("[TB] T5 reset mid-transfer");
        clearLogs();
        d0 = doneCount;
        h0 = hsTotal;
        applyStimulus(8'h40, 16'd8, 1'b1);
        for (int i = 0; i < 50; i++) begin
            if (hsTotal >= h0 + 2) break;
            @(posedge clk);
            #1;
        end
        checkOutput("t5_two_sent", (hsTotal >= h0 + 2) ? 32'd1 : 32'd0, 32'd1);
        srst_in = 1'b1;
        @(posedge clk);
        #1;
        srst_in = 1'b0;
        checkResetValues("t5_reset");
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t5_no_done", 32'(doneCount - d0), 32'd0);
        clearLogs();
        applyStimulus(8'h50, 16'd3, 1'b1);
        waitIdle("t5", 40);
        checkOutput("t5_words", hsLog.size(), 3);
        checkOutput("t5_first_word", (hsLog.size() > 0) ? {16'd0, hsLog[0]} : 32'hDEAD_BEEF, 32'h50AF);
        checkOutput("t5_done_count", 32'(doneCount - d0), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
